uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter among `N_REQ` requesters. Each requester offers one byte at a time through a req/ack handshake and may lock the transmitter for a multi-byte packet. The block sits between the client logic and the UART TX datapath. It sequences `tx_start` against the transmitter's `tx_busy`/`tx_done` status and guards against a hung transmitter with a timeout.

## Interface
- `D_W`, 8, data width per byte
- `N_REQ`, 4, number of requesters (≥2)
- `TO_CYC`, 200000, clock cycles allowed from `tx_start` to `tx_done` before abort
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req`  in  N_REQ  per-requester request; held until `ack` or withdrawn
- `req_data`  in  N_REQ*D_W  byte of requester i at bits [i*D_W +: D_W]; stable while `req[i]`
- `req_last`  in  N_REQ  requester i's current byte ends its packet
- `grant`  out  N_REQ  one-hot registered owner indication; all-zero when idle
- `ack`  out  N_REQ  1-cycle pulse: requester's current byte accepted
- `tx_data`  out  D_W  byte to transmitter, valid with `tx_start`
- `tx_start`  out  1  1-cycle pulse launching a frame
- `tx_busy`  in  1  transmitter shifting a frame
- `tx_done`  in  1  1-cycle pulse at end of stop bit
- `err_timeout`  out  1  1-cycle pulse when `TO_CYC` expires

## Operation
- **States:** IDLE, SEND, WAIT.
- **Pointer:** round-robin pointer `ptr` ($clog2(N_REQ) bits).
- **Latched owner:** owner index `idx` and flag `last_q` are latched.
- **IDLE:**
  - `grant` = 0.
  - If any `req` is set, select the first set bit scanning upward from `ptr` with wrap.
  - Latch `idx`, set `grant[idx]`, go to SEND.
- **SEND:**
  - If `req[idx]` = 0 (withdrawn): clear `grant`, set `ptr` ← `idx`+1 (mod `N_REQ`), go to IDLE; no `ack`.
  - Else if `tx_busy` = 0: drive `tx_data` ← `req_data[idx]`, pulse `tx_start` and `ack[idx]`, latch `last_q` ← `req_last[idx]`, clear the timeout counter, go to WAIT.
  - Else remain in SEND.
- **WAIT:**
  - The timeout counter ($clog2(TO_CYC+1) bits, saturating) increments each cycle.
  - On `tx_done`:
    - If `last_q` = 1: clear `grant`, advance `ptr` to `idx`+1, go to IDLE.
    - Else: keep `grant` and go to SEND (packet lock).
  - If the counter reaches `TO_CYC`-1 without `tx_done`: pulse `err_timeout`, clear `grant`, advance `ptr`, go to IDLE.
- **Packet lock:** other requests are ignored while `grant` is held. Ownership changes only via IDLE, so `grant` is all-zero for at least one cycle between owners.
- **Requester rule:** after `ack`, present the next byte (or drop `req`) before the owner's next SEND evaluation, i.e. within one cycle of `tx_done`.
- **`tx_data`:** holds its last value between starts.

## Timing
- **Reset:** `grant`, `ack`, `tx_data`, `tx_start`, `err_timeout` = 0; `ptr` = 0; state IDLE; counter = 0. Reset mid-packet drops `grant` the next edge; no `ack` or `tx_start` is issued.
- **Request latency:** `req` high at edge t (IDLE) → `grant` at t+1 → `tx_start`/`ack` at t+2 if `tx_busy` = 0 at t+1.
- **Busy stall:** SEND stalls indefinitely while `tx_busy` = 1; no timeout in SEND.
- **Back-to-back bytes:** `tx_done` at cycle d → SEND at d+1 → `tx_start` at d+2.
- **Release:** release at cycle d → IDLE at d+1 → next `grant` at d+2.
- **`tx_done` vs timeout:** `tx_done` in the same cycle the timeout expires counts as done; no `err_timeout`.
- **Spurious `tx_done`:** ignored in IDLE and SEND.
- **Simultaneous withdraw and `tx_busy`:** `req[idx]` dropping in the same cycle `tx_busy` falls is treated as a withdrawal; no start.
- **Outputs:** all outputs are registered; `ack` and `tx_start` are asserted in the same cycle.

## Test plan
- **Round-robin order:** `N_REQ`=4, `req`=4'b1111, `req_last`=1111, `tx_busy`=0, `tx_done` 20 cycles after each start → grants in order 0,1,2,3,0; each byte on `tx_data` matches its owner's `req_data`.
- **Packet lock:** req0 sends 0xA1,0xA2,0xA3 (last on 0xA3) while req2 is held high → three consecutive starts with `grant`=0001, then an idle cycle, then `grant`=0100.
- **Busy stall and timing:** `tx_busy`=1 for 10 cycles after grant → no `tx_start` until the cycle after `tx_busy` falls; `ack` coincides with `tx_start`.
- **Timeout:** `TO_CYC`=50, `tx_done` never arrives → `err_timeout` pulses exactly 50 cycles after `tx_start`, `grant` clears, the next requester is granted.
- **Withdrawal:** req1 drops `req` while in SEND with `tx_busy`=1 → `grant` clears, no `ack`, `ptr` = 2. A separate case with `tx_done` on the same cycle as the timeout expiry → no `err_timeout`.
- **Reset mid-packet:** `rst` during WAIT of a 3-byte packet → all outputs 0 next cycle; after release, `req`=0010 gets `grant` starting from `ptr`=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters,
// with packet locking and a transmitter-hang timeout.
module uart_tx_arbiter #(
  parameter int D_W    = 8,
  parameter int N_REQ  = 4,
  parameter int TO_CYC = 200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*D_W-1:0]   req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic [D_W-1:0]         tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   err_timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [PW-1:0]    idx_reg, idx_next;
  logic             last_reg, last_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [N_REQ-1:0] ack_reg, ack_next;
  logic [D_W-1:0]   tx_data_reg, tx_data_next;
  logic             tx_start_reg, tx_start_next;
  logic             err_reg, err_next;

  // (base + off) mod N_REQ, valid for base, off < N_REQ
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(N_REQ)) s = s - (PW+1)'(N_REQ);
    return s[PW-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Requests rotated so that position 0 is the requester at ptr
  logic [N_REQ-1:0] rot_req;
  logic [PW-1:0]    rot_idx [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot_idx[gi] = wrap_add(ptr_reg, gi);
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  // Scan downward so the lowest rotated position wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx[k];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    idx_next      = idx_reg;
    last_next     = last_reg;
    cnt_next      = cnt_reg;
    grant_next    = grant_reg;
    ack_next      = '0;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        grant_next = '0;
        if (pick_valid) begin
          idx_next   = pick_idx;
          grant_next = onehot(pick_idx);
          state_next = S_SEND;
        end
      end

      S_SEND: begin
        // Withdrawal takes priority over a transmitter that just went free
        if (!req[idx_reg]) begin
          grant_next = '0;
          ptr_next   = wrap_add(idx_reg, 1);
          state_next = S_IDLE;
        end else if (!tx_busy) begin
          tx_data_next  = req_data[idx_reg*D_W +: D_W];
          tx_start_next = 1'b1;
          ack_next      = onehot(idx_reg);
          last_next     = req_last[idx_reg];
          cnt_next      = '0;
          state_next    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (tx_done) begin
          if (last_reg) begin
            grant_next = '0;
            ptr_next   = wrap_add(idx_reg, 1);
            state_next = S_IDLE;
          end else begin
            state_next = S_SEND;
          end
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          grant_next = '0;
          ptr_next   = wrap_add(idx_reg, 1);
          state_next = S_IDLE;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        grant_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      idx_reg      <= '0;
      last_reg     <= 1'b0;
      cnt_reg      <= '0;
      grant_reg    <= '0;
      ack_reg      <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      idx_reg      <= idx_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
      grant_reg    <= grant_next;
      ack_reg      <= ack_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      err_reg      <= err_next;
    end
  end

  assign grant       = grant_reg;
  assign ack         = ack_reg;
  assign tx_data     = tx_data_reg;
  assign tx_start    = tx_start_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration vector table, hand-written corner
// sequences, then random traffic against a packet-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 50;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    grant;
  logic [N-1:0]    ack;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic            tx_done;
  logic            err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.D_W(DW), .N_REQ(N), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .grant(grant), .ack(ack), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] rq;
    int         busy;
    logic [7:0] base;
    logic [3:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_data = '0; req_last = '0; tx_busy = 1'b0; tx_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base ^ 8'(i);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Reference requester packets for the random phase
  logic [7:0] pk_data [N][4];
  int         pk_len  [N];
  int         pk_pos  [N];

  task automatic drive_requesters();
    for (int i = 0; i < N; i++) begin
      if (pk_pos[i] == pk_len[i] && $urandom_range(0, 3) == 0) begin
        pk_len[i] = int'($urandom_range(1, 3));
        pk_pos[i] = 0;
        for (int j = 0; j < 4; j++) pk_data[i][j] = 8'($urandom);
      end
      if (pk_pos[i] < pk_len[i]) begin
        req[i] = 1'b1;
        req_data[i*DW +: DW] = pk_data[i][pk_pos[i]];
        req_last[i] = (pk_pos[i] == pk_len[i] - 1);
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] lock_bytes [3];
    int err_at;
    int m_ptr, m_owner, start_due, rel_due, done_at, p;
    logic cur_last, exp_s;
    logic [3:0] m_req_prev, exp_g;

    vecs[0] = '{4'b0001, 0,  8'h10, 4'b0001, 8'h10};
    vecs[1] = '{4'b0011, 3,  8'h20, 4'b0010, 8'h21};
    vecs[2] = '{4'b0011, 0,  8'h30, 4'b0001, 8'h30};
    vecs[3] = '{4'b1000, 2,  8'h40, 4'b1000, 8'h43};
    vecs[4] = '{4'b1110, 0,  8'h50, 4'b0010, 8'h51};
    vecs[5] = '{4'b1101, 5,  8'h60, 4'b0100, 8'h62};
    vecs[6] = '{4'b1010, 0,  8'h70, 4'b1000, 8'h73};
    vecs[7] = '{4'b0101, 1,  8'h80, 4'b0001, 8'h80};
    vecs[8] = '{4'b0001, 10, 8'h90, 4'b0001, 8'h90};
    vecs[9] = '{4'b1111, 0,  8'hA4, 4'b0010, 8'hA5};
    lock_bytes[0] = 8'hA1; lock_bytes[1] = 8'hA2; lock_bytes[2] = 8'hA3;

    do_reset();
    chk("reset_grant", 32'(grant), 0);
    chk("reset_ack", 32'(ack), 0);
    chk("reset_tx_start", 32'(tx_start), 0);
    chk("reset_tx_data", 32'(tx_data), 0);
    chk("reset_err", 32'(err_timeout), 0);

    // Arbitration table: one single-byte packet per entry, pointer carried over
    for (int e = 0; e < 10; e++) begin
      req = vecs[e].rq; req_last = 4'hF; set_data(vecs[e].base);
      tx_busy = (vecs[e].busy > 0);
      step();
      chk($sformatf("vec%0d_grant", e), 32'(grant), 32'(vecs[e].exp_grant));
      chk($sformatf("vec%0d_nostart", e), 32'(tx_start), 0);
      for (int k = 0; k < vecs[e].busy; k++) begin
        step();
        chk($sformatf("vec%0d_stall", e), 32'(tx_start), 0);
      end
      tx_busy = 1'b0;
      step();
      chk($sformatf("vec%0d_start", e), 32'(tx_start), 1);
      chk($sformatf("vec%0d_ack", e), 32'(ack), 32'(vecs[e].exp_grant));
      chk($sformatf("vec%0d_data", e), 32'(tx_data), 32'(vecs[e].exp_data));
      req = '0; tx_busy = 1'b1;
      step();
      chk($sformatf("vec%0d_hold", e), 32'(grant), 32'(vecs[e].exp_grant));
      tx_busy = 1'b0; tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk($sformatf("vec%0d_release", e), 32'(grant), 0);
      step();
    end

    // Packet lock: req0 sends three bytes while req2 waits
    do_reset();
    req = 4'b0101; req_last = 4'b0100; req_data = 32'h00C1_00A1;
    step();
    chk("lock_grant0", 32'(grant), 32'b0001);
    for (int b = 0; b < 3; b++) begin
      step();
      chk("lock_start", 32'(tx_start), 1);
      chk("lock_data", 32'(tx_data), 32'(lock_bytes[b]));
      chk("lock_ack", 32'(ack), 32'b0001);
      if (b < 2) begin
        req_data[7:0] = lock_bytes[b+1];
        req_last[0] = (b == 1);
      end else begin
        req[0] = 1'b0;
      end
      tx_busy = 1'b1;
      repeat (3) begin
        step();
        chk("lock_hold", 32'(grant), 32'b0001);
      end
      tx_busy = 1'b0; tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("lock_after_done", 32'(grant), (b < 2) ? 32'b0001 : 32'b0000);
      chk("lock_no_early_start", 32'(tx_start), 0);
    end
    step();
    chk("lock_grant2", 32'(grant), 32'b0100);
    step();
    chk("lock_req2_data", 32'(tx_data), 32'hC1);
    chk("lock_req2_ack", 32'(ack), 32'b0100);
    req = '0; tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("lock_req2_release", 32'(grant), 0);

    // Timeout: pointer is 3 here, so req0 wins, then req2 after abort
    req = 4'b0101; req_last = 4'hF; req_data = 32'h00B2_00B0;
    step();
    chk("to_grant", 32'(grant), 32'b0001);
    step();
    chk("to_start", 32'(tx_start), 1);
    req_data[7:0] = 8'hB1; tx_busy = 1'b1;
    err_at = -1;
    for (int k = 1; k <= TO + 5 && err_at < 0; k++) begin
      step();
      if (err_timeout) err_at = k;
    end
    chk("to_err_cycle", 32'(err_at), 32'(TO));
    chk("to_grant_cleared", 32'(grant), 0);
    tx_busy = 1'b0;
    step();
    chk("to_err_pulse", 32'(err_timeout), 0);
    chk("to_next_grant", 32'(grant), 32'b0100);

    // Withdrawal while busy, then withdrawal in the cycle busy falls
    do_reset();
    req = 4'b0010; req_last = 4'hF; set_data(8'h00); tx_busy = 1'b1;
    step();
    chk("wd_grant", 32'(grant), 32'b0010);
    step();
    chk("wd_stall", 32'(tx_start), 0);
    req = '0;
    step();
    chk("wd_grant_clear", 32'(grant), 0);
    chk("wd_no_ack", 32'(ack), 0);
    req = 4'b0111;
    step();
    chk("wd_ptr2", 32'(grant), 32'b0100);
    step();
    chk("wd2_stall", 32'(tx_start), 0);
    req = '0; tx_busy = 1'b0;
    step();
    chk("wd2_grant_clear", 32'(grant), 0);
    chk("wd2_no_start", 32'(tx_start), 0);
    chk("wd2_no_ack", 32'(ack), 0);
    req = 4'b0111;
    step();
    chk("wd2_ptr3", 32'(grant), 32'b0001);
    req = '0;
    step();
    step();

    // tx_done on the very cycle the timeout would expire
    req = 4'b0001; req_data[7:0] = 8'hD0;
    step();
    chk("dx_grant", 32'(grant), 32'b0001);
    step();
    chk("dx_start", 32'(tx_start), 1);
    req = '0; tx_busy = 1'b1;
    repeat (TO - 1) begin
      step();
      chk("dx_no_err_early", 32'(err_timeout), 0);
    end
    tx_busy = 1'b0; tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("dx_no_err", 32'(err_timeout), 0);
    chk("dx_release", 32'(grant), 0);
    step();
    chk("dx_no_err_after", 32'(err_timeout), 0);

    // Reset in the middle of a packet
    do_reset();
    req = 4'b0100; req_last = 4'b0000; req_data = 32'h00E1_0000;
    step();
    chk("rm_grant", 32'(grant), 32'b0100);
    step();
    chk("rm_start", 32'(tx_start), 1);
    req_data[23:16] = 8'hE2; tx_busy = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rm_grant0", 32'(grant), 0);
    chk("rm_ack0", 32'(ack), 0);
    chk("rm_start0", 32'(tx_start), 0);
    chk("rm_data0", 32'(tx_data), 0);
    chk("rm_err0", 32'(err_timeout), 0);
    rst = 1'b0; tx_busy = 1'b0; req = 4'b1010; req_last = 4'hF;
    step();
    chk("rm_ptr0", 32'(grant), 32'b0010);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < N; i++) begin pk_len[i] = 0; pk_pos[i] = 0; end
    m_ptr = 0; m_owner = -1; start_due = -1; rel_due = -1; done_at = -1; cur_last = 1'b0;
    drive_requesters();
    m_req_prev = req;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (rel_due == cyc) begin
        chk("rnd_release", 32'(grant), 0);
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        rel_due = -1;
      end else if (m_owner < 0) begin
        p = rr_pick(m_req_prev, m_ptr);
        exp_g = (p < 0) ? 4'b0000 : 4'(1 << p);
        chk("rnd_grant", 32'(grant), 32'(exp_g));
        if (p >= 0) begin
          m_owner = p;
          start_due = cyc + 1;
        end
      end else begin
        chk("rnd_hold", 32'(grant), 32'(1 << m_owner));
      end
      exp_s = (start_due == cyc) && (m_owner >= 0);
      chk("rnd_start", 32'(tx_start), 32'(exp_s));
      chk("rnd_ack", 32'(ack), exp_s ? 32'(1 << m_owner) : 32'd0);
      chk("rnd_err", 32'(err_timeout), 0);
      tx_done = 1'b0;
      if (exp_s) begin
        chk("rnd_data", 32'(tx_data), 32'(pk_data[m_owner][pk_pos[m_owner]]));
        cur_last = (pk_pos[m_owner] == pk_len[m_owner] - 1);
        pk_pos[m_owner]++;
        start_due = -1;
        done_at = cyc + int'($urandom_range(1, 30));
        tx_busy = 1'b1;
      end else if (cyc == done_at) begin
        tx_done = 1'b1;
        tx_busy = 1'b0;
        done_at = -1;
        if (cur_last) rel_due = cyc + 1;
        else start_due = cyc + 2;
      end
      drive_requesters();
      m_req_prev = req;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
